// File: rtl/xilinx_fifo_sync_arbiter.sv
// Reset sequencer, round-robin write arbiter and read gate
// for one 7-series synchronous FIFO.
module xilinx_fifo_sync_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int RST_CYCLES = 5,
  parameter int RST_GUARD  = 2
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          rd_en,
  input  logic                          flush,
  output logic                          busy,
  output logic [15:0]                   err_cnt,
  output logic                          FIFO_RST,
  output logic                          FIFO_WREN,
  output logic [DATA_WIDTH-1:0]         FIFO_DI,
  output logic                          FIFO_RDEN,
  input  logic                          FIFO_FULL,
  input  logic                          FIFO_EMPTY,
  input  logic                          FIFO_WRERR,
  input  logic                          FIFO_RDERR
);

  localparam int CNT_MAX =
    (RST_CYCLES > RST_GUARD) ? RST_CYCLES : RST_GUARD;
  localparam int CW = $clog2(CNT_MAX);
  localparam int PW = $clog2(NUM_REQ);

  localparam int S_PRE  = 0;
  localparam int S_HOLD = 1;
  localparam int S_POST = 2;
  localparam int S_RUN  = 3;

  localparam logic [3:0] PRE_OH  = 4'b0001;
  localparam logic [3:0] HOLD_OH = 4'b0010;
  localparam logic [3:0] POST_OH = 4'b0100;
  localparam logic [3:0] RUN_OH  = 4'b1000;

  localparam logic [CW-1:0] CNT_RST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] CNT_GRD = CW'(RST_GUARD - 1);

  logic [3:0]    state;
  logic [3:0]    state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          run;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_inc;
  logic [PW-1:0] gnt_idx;
  logic [PW:0]   sum;
  logic          hit;
  logic          grant;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= HOLD_OH;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (1'b1)
      state[S_PRE]: begin
        if (cnt == CNT_GRD) begin
          state_nx = HOLD_OH;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      state[S_HOLD]: begin
        if (cnt == CNT_RST) begin
          state_nx = POST_OH;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      state[S_POST]: begin
        if (cnt == CNT_GRD) begin
          state_nx = RUN_OH;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      state[S_RUN]: begin
        if (flush) begin
          state_nx = PRE_OH;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = HOLD_OH;
        cnt_nx   = '0;
      end
    endcase
  end

  assign ptr_inc =
    (ptr == PW'(NUM_REQ - 1)) ? '0 : ptr + 1'b1;

  // Walk offsets high to low so the nearest requester after ptr wins.
  always_comb begin
    hit     = 1'b0;
    gnt_idx = ptr_inc;
    sum     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_REQ))
        sum = sum - (PW+1)'(NUM_REQ);
      if (req_valid[sum[PW-1:0]]) begin
        hit     = 1'b1;
        gnt_idx = sum[PW-1:0];
      end
    end
  end

  always_comb begin
    run       = state[S_RUN];
    busy      = !run;
    FIFO_RST  = state[S_HOLD];
    grant     = run & !FIFO_FULL & hit;
    FIFO_WREN = grant;
    req_ready = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
    FIFO_DI   = req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    FIFO_RDEN = run & rd_en & !FIFO_EMPTY;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr     <= PW'(NUM_REQ - 1);
      err_cnt <= '0;
    end else begin
      if (grant)
        ptr <= gnt_idx;
      if (run && flush)
        err_cnt <= '0;
      else if (run && (FIFO_WRERR || FIFO_RDERR)
               && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_xilinx_fifo_sync_arbiter.sv
// Randomized bench for xilinx_fifo_sync_arbiter with a
// timeline/queue reference model and an emulated FIFO.
module tb_xilinx_fifo_sync_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int C = 5;
  localparam int G = 2;
  localparam int D = 16;

  logic           CLK = 1'b0;
  logic           RST_N = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           rd_en = 1'b0;
  logic           flush = 1'b0;
  logic           busy;
  logic [15:0]    err_cnt;
  logic           FIFO_RST;
  logic           FIFO_WREN;
  logic [W-1:0]   FIFO_DI;
  logic           FIFO_RDEN;
  logic           FIFO_FULL = 1'b0;
  logic           FIFO_EMPTY = 1'b1;
  logic           FIFO_WRERR = 1'b0;
  logic           FIFO_RDERR = 1'b0;

  always #5 CLK = ~CLK;

  xilinx_fifo_sync_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(W),
    .RST_CYCLES(C), .RST_GUARD(G)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rd_en(rd_en),
    .flush(flush), .busy(busy), .err_cnt(err_cnt),
    .FIFO_RST(FIFO_RST), .FIFO_WREN(FIFO_WREN),
    .FIFO_DI(FIFO_DI), .FIFO_RDEN(FIFO_RDEN),
    .FIFO_FULL(FIFO_FULL), .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_WRERR(FIFO_WRERR), .FIFO_RDERR(FIFO_RDERR)
  );

  int n_chk;
  int n_fail;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: time since reset release or flush
  int           t;
  bit           ff;
  int           ptr;
  int           err;
  logic [W-1:0] fq[$];
  logic [W-1:0] eq[$];
  bit           pend[N];
  logic [W-1:0] pdat[N];

  int           pv;
  int           prd;
  int           pfl;
  int           per;
  logic [N-1:0] mask;
  bit           force_wrerr;
  bit           force_flush;

  task automatic run_cycles(input int n);
    int           off;
    bit           run;
    bit           erst;
    bit           erden;
    int           g;
    logic [N-1:0] erdy;
    logic         dwren;
    logic         drden;
    logic         drst;
    logic [W-1:0] ddi;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           pa;
    bit           pb;
    repeat (n) begin
      @(negedge CLK);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && mask[i] && $urandom_range(99) < pv) begin
          pend[i] = 1'b1;
          pdat[i] = W'($urandom);
        end
        req_valid[i] = pend[i];
        req_data[i*W +: W] = pend[i] ? pdat[i] : W'($urandom);
      end
      rd_en = $urandom_range(99) < prd;
      flush = force_flush || ($urandom_range(999) < pfl);
      force_flush = 1'b0;
      FIFO_WRERR = force_wrerr || ($urandom_range(99) < per);
      FIFO_RDERR = $urandom_range(99) < per;
      FIFO_FULL = fq.size() >= D;
      FIFO_EMPTY = fq.size() == 0;
      #1;
      off  = ff ? G : 0;
      run  = t >= off + C + G;
      erst = t >= off && t < off + C;
      g = -1;
      if (run && !FIFO_FULL) begin
        for (int k = 1; k <= N; k++) begin
          if (req_valid[(ptr + k) % N]) begin
            g = (ptr + k) % N;
            break;
          end
        end
      end
      erdy  = (g >= 0) ? N'(1 << g) : '0;
      erden = run && rd_en && !FIFO_EMPTY;
      chk("busy", busy, !run);
      chk("fifo_rst", FIFO_RST, erst);
      chk("req_ready", req_ready, erdy);
      chk("wren", FIFO_WREN, g >= 0);
      chk("rden", FIFO_RDEN, erden);
      chk("err_cnt", err_cnt, err);
      if (g >= 0) chk("fifo_di", FIFO_DI, pdat[g]);
      dwren = FIFO_WREN;
      drden = FIFO_RDEN;
      drst  = FIFO_RST;
      ddi   = FIFO_DI;
      @(posedge CLK);
      pa = 1'b0;
      pb = 1'b0;
      if (drst) fq.delete();
      else begin
        if (drden && fq.size() > 0) begin a = fq.pop_front(); pa = 1'b1; end
        if (dwren && fq.size() < D) fq.push_back(ddi);
      end
      if (erst) eq.delete();
      else if (erden && eq.size() > 0) begin
        b = eq.pop_front();
        pb = 1'b1;
      end
      if (pa && pb) chk("rd_data", a, b);
      if (g >= 0) begin
        if (!erst) eq.push_back(pdat[g]);
        pend[g] = 1'b0;
        ptr = g;
      end
      if (run && (FIFO_WRERR || FIFO_RDERR) && err < 65535) err++;
      if (run && flush) begin
        err = 0;
        ff  = 1'b1;
        t   = 0;
      end else if (t < 100000) t++;
    end
  endtask

  task automatic model_reset();
    t   = 0;
    ff  = 1'b0;
    ptr = N - 1;
    err = 0;
    fq.delete();
    eq.delete();
  endtask

  task automatic reset_mid();
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b1);
    chk("rst_fifo_rst", FIFO_RST, 1'b1);
    chk("rst_ready", req_ready, '0);
    chk("rst_wren", FIFO_WREN, 1'b0);
    chk("rst_err", err_cnt, 16'h0);
    model_reset();
    @(posedge CLK);
    #2 RST_N = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    pv = 0; prd = 0; pfl = 0; per = 0;
    mask = '1;
    force_wrerr = 1'b0;
    force_flush = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      pdat[i] = '0;
    end
    model_reset();
    #1 RST_N = 1'b0;
    #2;
    chk("init_busy", busy, 1'b1);
    chk("init_fifo_rst", FIFO_RST, 1'b1);
    chk("init_err", err_cnt, 16'h0);
    chk("init_rden", FIFO_RDEN, 1'b0);
    @(posedge CLK);
    #2 RST_N = 1'b1;

    run_cycles(9);
    pv = 100; prd = 100;
    run_cycles(12);
    mask = 4'b1010;
    run_cycles(8);

    mask = 4'b0100; prd = 0;
    run_cycles(30);
    chk("full_level", fq.size(), D);
    chk("full_err", err_cnt, 16'h0);

    pv = 0; prd = 100;
    run_cycles(20);
    chk("drained", fq.size(), 0);

    mask = '1; pv = 40; prd = 50; per = 5; pfl = 15;
    run_cycles(2000);
    reset_mid();
    run_cycles(300);

    pfl = 0; per = 0;
    force_flush = 1'b1;
    pv = 60; prd = 20;
    run_cycles(15);
    pv = 0; prd = 100;
    run_cycles(30);
    chk("flush_empty", fq.size(), 0);

    force_wrerr = 1'b1;
    run_cycles(70000);
    chk("err_sat", err_cnt, 16'hFFFF);
    force_wrerr = 1'b0;

    force_flush = 1'b1;
    run_cycles(4);
    reset_mid();
    pv = 50; prd = 50;
    run_cycles(20);
    chk("post_rst_err", err_cnt, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
